// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Optional even-parity bit is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // Register offsets, decoded from Address[3:2]
  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;

  // STATUS bit positions
  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;

  // FIFO count as reported in STATUS[7:4], clamped to 15
  function automatic logic [3:0] sat_cnt(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with async reset. Push while full and pop while empty
// are ignored; DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy update; push and pop on one edge cancel in the count
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer/count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA pushes into a FIFO, STATUS reports
// full/empty/busy/overflow/count, bytes go out 8N1 LSB first on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovf_q, ovf_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [1:0]      offset;
  logic            wr_tx, wr_st, pop, bit_done;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_cnt;
  logic [DATA_WIDTH-1:0] status;
  logic            unused_wdata;

  assign offset       = Address[3:2];
  assign wr_tx        = sel & MemWrite & (offset == TXDATA_OFS);
  assign wr_st        = sel & MemWrite & (offset == STATUS_OFS);
  assign bit_done     = (baud_q == BAUD_LAST);
  assign tx           = tx_q;
  assign unused_wdata = ^{Address[DATA_WIDTH-1:4], Address[1:0], WriteData[DATA_WIDTH-1:8]};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Status word and combinational load path
  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_BUSY]             = (state_q != IDLE);
    status[ST_OVF]              = ovf_q;
    status[ST_CNT_LO +: 4]      = sat_cnt(32'(fifo_cnt));
    ReadData                    = '0;
    if (sel && MemRead && offset == STATUS_OFS) ReadData = status;
  end

  // Sticky overflow: a dropped push sets it, writing 1 to bit3 clears it
  always_comb begin
    ovf_d = ovf_q;
    if (wr_tx && fifo_full)          ovf_d = 1'b1;
    else if (wr_st && WriteData[3])  ovf_d = 1'b0;
  end

  // Frame FSM next state, baud counter, shifter; tx is registered from the
  // current state so the line trails the state by one cycle
  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE, STOP: begin
        if (state_q == STOP && bit_done) state_d = IDLE;
        if ((state_q == IDLE || bit_done) && !fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
          shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_dout;
`endif
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (bit_done) state_d = STOP;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset forces the line high and abandons any frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
